prime_factorizer: RTL and testbench

- Takes one unsigned integer and streams out its prime factors in ascending order, with repeated factors emitted once per multiplicity.
- Uses trial division with an internal sequential divider, one factor per valid/ready transfer.
- Acts as the decomposition counterpart to the prime generator/summer (primer): primer builds values from primes, this block breaks a value back into primes.
- Feeds the practice benches and later checker logic.

---
 rtl/prime_factorizer.sv | 207 ++++++++++++++++++++
 tb/tb_prime_factorizer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prime_factorizer.sv
// ---------------------------------------------------------------------------
// prime_factorizer
//
// Breaks one unsigned integer into its prime factors by trial division and
// streams them out in ascending order, one factor per valid/ready transfer.
// Repeated factors are emitted once per multiplicity. The trial divisor
// starts at 2, then walks the odd numbers; each trial uses a restoring
// divider that resolves one quotient bit per cycle (WIDTH cycles per trial).
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   start         job request, sampled only while idle
//   n_in          operand, captured when start is accepted
//   busy          high from the cycle after start until the done cycle ends
//   factor        current prime factor (meaningful while factor_valid)
//   factor_valid  factor handshake valid
//   factor_ready  downstream ready
//   done          one-cycle pulse after the last factor has transferred
//   count         factors transferred in the current or last job
// ---------------------------------------------------------------------------
module prime_factorizer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] n_in,
    output logic             busy,
    output logic [WIDTH-1:0] factor,
    output logic             factor_valid,
    input  logic             factor_ready,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DIV,
        S_EVAL,
        S_EMIT,
        S_LAST,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] n;      // remaining value still to be factored
    logic [WIDTH-1:0] d;      // current trial divisor
    logic [WIDTH-1:0] q;      // dividend shifts out of the top, quotient in at the bottom
    logic [WIDTH-1:0] r;      // partial remainder
    logic [CNT_W-1:0] shift;  // divider step counter

    // d*d against n at double width so the square never overflows.
    logic [2*WIDTH-1:0] d_sq;
    logic               d_sq_gt_n;

    // One restoring-division step.
    logic [WIDTH:0]   r_trial;
    logic             sub_ok;
    logic [WIDTH-1:0] r_diff;

    logic xfer;
    logic n_lt_2;
    logic div_last;

    always_comb begin
        d_sq      = {{WIDTH{1'b0}}, d} * {{WIDTH{1'b0}}, d};
        d_sq_gt_n = d_sq > {{WIDTH{1'b0}}, n};
        n_lt_2    = n < WIDTH'(2);
        r_trial   = {r, q[WIDTH-1]};
        sub_ok    = r_trial >= {1'b0, d};
        // The true difference is below d, so it fits in WIDTH bits.
        r_diff    = r_trial[WIDTH-1:0] - d;
        div_last  = shift == CNT_W'(WIDTH - 1);
    end

    // ------------------------------------------------------------------
    // Outputs decode straight from the state register, so an asynchronous
    // reset clears them immediately.
    // ------------------------------------------------------------------
    always_comb begin
        busy         = 1'b0;
        factor       = '0;
        factor_valid = 1'b0;
        done         = 1'b0;
        case (state)
            S_IDLE: ;
            S_EMIT: begin
                busy         = 1'b1;
                factor       = d;
                factor_valid = 1'b1;
            end
            S_LAST: begin
                busy = 1'b1;
                if (!n_lt_2 && n != WIDTH'(1)) begin
                    factor       = n;
                    factor_valid = 1'b1;
                end
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b1;
        endcase
    end

    assign xfer = factor_valid && factor_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_CHECK;
            end
            S_CHECK: begin
                if (n_lt_2)         state_next = S_DONE;
                else if (d_sq_gt_n) state_next = S_LAST;
                else                state_next = S_DIV;
            end
            S_DIV: begin
                if (div_last) state_next = S_EVAL;
            end
            S_EVAL: begin
                if (r == '0) state_next = S_EMIT;
                else         state_next = S_CHECK;
            end
            S_EMIT: begin
                // d stays put so a repeated factor is tried again.
                if (xfer) state_next = S_CHECK;
            end
            S_LAST: begin
                if (!factor_valid || xfer) state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n     <= '0;
            d     <= '0;
            q     <= '0;
            r     <= '0;
            shift <= '0;
            count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n     <= n_in;
                        d     <= WIDTH'(2);
                        count <= '0;
                    end
                end
                S_CHECK: begin
                    if (!n_lt_2 && !d_sq_gt_n) begin
                        q     <= n;
                        r     <= '0;
                        shift <= '0;
                    end
                end
                S_DIV: begin
                    q     <= {q[WIDTH-2:0], sub_ok};
                    r     <= sub_ok ? r_diff : r_trial[WIDTH-1:0];
                    shift <= shift + CNT_W'(1);
                end
                S_EVAL: begin
                    if (r != '0) begin
                        // 2 -> 3, then odd divisors only. d stays far below
                        // 2^WIDTH before the d*d > n exit, so no wrap.
                        if (d == WIDTH'(2)) d <= WIDTH'(3);
                        else                d <= d + WIDTH'(2);
                    end
                end
                S_EMIT: begin
                    if (xfer) begin
                        n     <= q;
                        count <= count + CNT_W'(1);
                    end
                end
                S_LAST: begin
                    if (xfer) count <= count + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prime_factorizer.sv
// ---------------------------------------------------------------------------
// tb_prime_factorizer
//
// Directed bench for prime_factorizer (WIDTH=32, CNT_W=6). Each scenario is
// its own task with inline comparisons against hand-computed factor lists.
// Outputs are sampled on the falling clock edge; inputs change there too.
// ---------------------------------------------------------------------------
module tb_prime_factorizer;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] n_in = '0;
    logic             busy;
    logic [WIDTH-1:0] factor;
    logic             factor_valid;
    logic             factor_ready = 1'b1;
    logic             done;
    logic [CNT_W-1:0] count;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] got[$];
    int               dones;
    bit               saw_valid;

    always #5 clk = ~clk;

    prime_factorizer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .n_in         (n_in),
        .busy         (busy),
        .factor       (factor),
        .factor_valid (factor_valid),
        .factor_ready (factor_ready),
        .done         (done),
        .count        (count)
    );

    // Pulse start for one cycle; returns on the falling edge after acceptance.
    task automatic do_start(input logic [WIDTH-1:0] value);
        @(negedge clk);
        n_in  = value;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Gathers transferred factors until done; samples the current falling
    // edge first, then advances. Returns on the done cycle.
    task automatic collect(input int budget, output bit timeout);
        got.delete();
        timeout = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (factor_valid) saw_valid = 1'b1;
            if (factor_valid && factor_ready) got.push_back(factor);
            if (done) begin
                dones++;
                timeout = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, factor_valid, done} !== 3'b000 || factor !== '0 || count !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b valid=%b done=%b factor=%0d count=%0d, required all 0",
                     busy, factor_valid, done, factor, count);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_twelve();
        bit to;
        logic [WIDTH-1:0] exp[$] = '{32'd2, 32'd2, 32'd3};
        factor_ready = 1'b1;
        dones = 0;
        do_start(32'd12);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL twelve_busy_rise: busy=%b, required 1", busy);
        end
        collect(2000, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL twelve_timeout: done not seen, required done within budget");
        end
        checks++;
        if (got.size() != exp.size()) begin
            errors++;
            $display("FAIL twelve_nfactors: got %0d, required %0d", got.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                errors++;
                $display("FAIL twelve_factor%0d: got %0d, required %0d", i,
                         (i < got.size()) ? got[i] : '0, exp[i]);
            end
        end
        checks++;
        if (count !== CNT_W'(3)) begin
            errors++;
            $display("FAIL twelve_count: got %0d, required 3", count);
        end
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++;
        if (busy !== 1'b0 || dones != 1) begin
            errors++;
            $display("FAIL twelve_after: busy=%b dones=%0d, required busy=0 dones=1", busy, dones);
        end
    endtask

    task automatic test_prime_97();
        bit to;
        dones = 0;
        do_start(32'd97);
        collect(2000, to);
        checks++;
        if (to || got.size() != 1 || got[0] !== 32'd97) begin
            errors++;
            $display("FAIL prime97_factors: timeout=%b n=%0d first=%0d, required single factor 97",
                     to, got.size(), (got.size() > 0) ? got[0] : '0);
        end
        checks++;
        if (count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL prime97_count: got %0d, required 1", count);
        end
    endtask

    task automatic test_zero_one();
        logic [WIDTH-1:0] vals[2] = '{32'd0, 32'd1};
        for (int k = 0; k < 2; k++) begin
            saw_valid = 1'b0;
            @(negedge clk);
            n_in  = vals[k];
            start = 1'b1;
            @(negedge clk);           // CHECK
            start = 1'b0;
            if (factor_valid) saw_valid = 1'b1;
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL small%0d_check_cycle: busy=%b done=%b, required 1/0", k, busy, done);
            end
            @(negedge clk);           // DONE
            if (factor_valid) saw_valid = 1'b1;
            checks++;
            if (done !== 1'b1 || count !== '0) begin
                errors++;
                $display("FAIL small%0d_done_cycle: done=%b count=%0d, required 1/0", k, done, count);
            end
            @(negedge clk);           // IDLE
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || saw_valid) begin
                errors++;
                $display("FAIL small%0d_idle: done=%b busy=%b saw_valid=%b, required 0/0/0",
                         k, done, busy, saw_valid);
            end
        end
    endtask

    task automatic test_all_ones();
        bit to;
        longint unsigned prod = 1;
        logic [WIDTH-1:0] exp[$] = '{32'd3, 32'd5, 32'd17, 32'd257, 32'd65537};
        dones = 0;
        do_start(32'hFFFF_FFFF);
        collect(20000, to);
        checks++;
        if (to || got.size() != exp.size()) begin
            errors++;
            $display("FAIL ones_nfactors: timeout=%b got %0d, required 5", to, got.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                errors++;
                $display("FAIL ones_factor%0d: got %0d, required %0d", i,
                         (i < got.size()) ? got[i] : '0, exp[i]);
            end
        end
        foreach (got[i]) prod = prod * longint'(got[i]);
        checks++;
        if (prod != 64'hFFFF_FFFF) begin
            errors++;
            $display("FAIL ones_product: got %0h, required ffffffff", prod);
        end
        checks++;
        if (count !== CNT_W'(5)) begin
            errors++;
            $display("FAIL ones_count: got %0d, required 5", count);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        bit seen;
        logic [WIDTH-1:0] exp[$] = '{32'd2, 32'd3, 32'd3};
        factor_ready = 1'b0;
        dones = 0;
        do_start(32'd18);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (factor_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL stall_first_valid: valid=0, required 1 within budget");
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (factor_valid !== 1'b1 || factor !== 32'd2) begin
                errors++;
                $display("FAIL stall_hold%0d: valid=%b factor=%0d, required 1/2", c, factor_valid, factor);
            end
            // Extra start while busy must be ignored.
            if (c == 1) begin
                n_in  = 32'd5;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (c < 4) @(negedge clk);
        end
        start = 1'b0;
        factor_ready = 1'b1;
        collect(2000, to);
        checks++;
        if (to || got.size() != exp.size()) begin
            errors++;
            $display("FAIL stall_nfactors: timeout=%b got %0d, required 3", to, got.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                errors++;
                $display("FAIL stall_factor%0d: got %0d, required %0d", i,
                         (i < got.size()) ? got[i] : '0, exp[i]);
            end
        end
        repeat (5) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++;
        if (count !== CNT_W'(3) || dones != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_busy_start: count=%0d dones=%0d busy=%b, required 3/1/0",
                     count, dones, busy);
        end
    endtask

    task automatic test_reset_mid_div();
        bit to;
        logic [WIDTH-1:0] exp[$] = '{32'd2, 32'd3};
        dones = 0;
        saw_valid = 1'b0;
        do_start(32'd1000003);
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL middiv_busy: busy=%b, required 1 before reset", busy);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({busy, factor_valid, done} !== 3'b000 || factor !== '0 || count !== '0) begin
            errors++;
            $display("FAIL middiv_reset_outputs: busy=%b valid=%b done=%b factor=%0d count=%0d, required 0",
                     busy, factor_valid, done, factor, count);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (factor_valid) saw_valid = 1'b1;
            if (done) dones++;
        end
        checks++;
        if (saw_valid || dones != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL middiv_aborted: saw_valid=%b dones=%0d busy=%b, required 0/0/0",
                     saw_valid, dones, busy);
        end
        do_start(32'd6);
        collect(2000, to);
        checks++;
        if (to || got.size() != exp.size()) begin
            errors++;
            $display("FAIL fresh6_nfactors: timeout=%b got %0d, required 2", to, got.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                errors++;
                $display("FAIL fresh6_factor%0d: got %0d, required %0d", i,
                         (i < got.size()) ? got[i] : '0, exp[i]);
            end
        end
        checks++;
        if (count !== CNT_W'(2)) begin
            errors++;
            $display("FAIL fresh6_count: got %0d, required 2", count);
        end
    endtask

    initial begin
        test_reset();
        test_twelve();
        test_prime_97();
        test_zero_one();
        test_all_ones();
        test_back_to_back();
        test_reset_mid_div();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
